// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each grant runs IDLE -> EXEC -> DONE; result/nzp stay registered until the next EXEC.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [2:0]  op0,
   input  logic [2:0]  op1,
   input  logic [15:0] a0,
   input  logic [15:0] b0,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   input  logic [3:0]  shift0,
   input  logic [3:0]  shift1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [15:0] result,
   output logic [2:0]  nzp,
   output logic        busy,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   output logic [2:0]  alu_op,
   output logic [3:0]  alu_shift,
   input  logic [15:0] alu_out,
   input  logic        alu_zero,
   input  logic        alu_negative
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q;
   logic [15:0] a_q, b_q;
   logic [3:0]  sh_q;
   logic        owner_q;
   logic        last_q;
   logic [15:0] result_q;
   logic [2:0]  nzp_q;

   logic        any_req;
   logic        win;

   assign any_req = req0 | req1;
   // On a tie the requester that was not served last wins; otherwise the lone requester.
   assign win     = (req0 & req1) ? ~last_q : req1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = EXEC;
         EXEC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      done0 = 1'b0;
      done1 = 1'b0;
      busy  = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            // Grant is combinational from the sampled request, so it is held off during reset.
            gnt0 = rst_n & any_req & ~win;
            gnt1 = rst_n & any_req & win;
         end
         DONE: begin
            done0 = ~owner_q;
            done1 = owner_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= 3'd0;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         sh_q     <= 4'd0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         result_q <= 16'h0000;
         nzp_q    <= 3'b010;
      end else begin
         case (state_q)
            IDLE: if (any_req) begin
               owner_q <= win;
               op_q    <= win ? op1    : op0;
               a_q     <= win ? a1     : a0;
               b_q     <= win ? b1     : b0;
               sh_q    <= win ? shift1 : shift0;
            end
            EXEC: begin
               result_q <= alu_out;
               nzp_q    <= {alu_negative, alu_zero, ~alu_negative & ~alu_zero};
            end
            DONE: last_q <= owner_q;
            default: ;
         endcase
      end
   end

   assign result    = result_q;
   assign nzp       = nzp_q;
   assign alu_in1   = a_q;
   assign alu_in2   = b_q;
   assign alu_op    = op_q;
   assign alu_shift = sh_q;

endmodule
